// File: rtl/game_flow_controller.sv
// game_flow_controller: gameplay sequencer (lives, level, food count, freeze timers); optional pause via GAME_FLOW_PAUSE_EN
module game_flow_controller #(
   parameter int          LIVES       = 3,
   parameter int          READY_TICKS = 120,
   parameter int          DEATH_TICKS = 90,
   parameter int          CLEAR_TICKS = 120,
   parameter logic [11:0] FOOD_TOTAL  = 12'd1000,
   parameter int          TICK_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       pacman_is_dead,
   input  logic       food_eaten,
`ifdef GAME_FLOW_PAUSE_EN
   input  logic       pause_btn,
`endif
   output logic [2:0] state,
   output logic       move_en,
   output logic       sprite_reset,
   output logic       score_clear,
   output logic       food_reload,
   output logic [3:0] lives_left,
   output logic [3:0] level,
   output logic       game_over
);
   typedef enum logic [2:0] {
      ATTRACT, READY, PLAY, DYING, LEVEL_CLEAR, GAME_OVER_S, PAUSED
   } state_t;
   state_t cur, state_n;
   logic [TICK_W-1:0] timer, timer_n;
   logic [11:0] food_cnt, food_n;
   logic [3:0] lives_n, level_n;
   logic sprite_n, score_n, reload_n, start_prev, start_rise, pause_rise, expire;
   assign start_rise = start_btn & ~start_prev;
   assign state = cur;
`ifdef GAME_FLOW_PAUSE_EN
   logic pause_prev;
   assign pause_rise = pause_btn & ~pause_prev;
   always_ff @(posedge clk) pause_prev <= rst | pause_btn;
`else
   assign pause_rise = 1'b0;
`endif
   // a tick finishes a freeze when it takes the timer from 1 to 0
   assign expire = frame_tick && timer <= TICK_W'(1);
   always_comb begin
      state_n  = cur;
      timer_n  = timer;
      lives_n  = lives_left;
      level_n  = level;
      food_n   = food_cnt;
      sprite_n = 1'b0;
      score_n  = 1'b0;
      reload_n = 1'b0;
      if (frame_tick && timer != '0 && (cur == READY || cur == DYING || cur == LEVEL_CLEAR))
         timer_n = timer - TICK_W'(1);
      case (cur)
         ATTRACT, GAME_OVER_S:
            if (start_rise) begin
               state_n  = READY;
               sprite_n = 1'b1;
               score_n  = 1'b1;
               reload_n = 1'b1;
               lives_n  = 4'(LIVES);
               level_n  = 4'd1;
               food_n   = '0;
               timer_n  = TICK_W'(READY_TICKS);
            end
         READY: state_n = expire ? PLAY : READY;
         PLAY: begin
            food_n = food_cnt + 12'(food_eaten);
            if (pacman_is_dead) begin
               state_n = DYING;
               lives_n = lives_left - 4'd1;
               timer_n = TICK_W'(DEATH_TICKS);
            end else if (food_n >= FOOD_TOTAL) begin
               state_n = LEVEL_CLEAR;
               timer_n = TICK_W'(CLEAR_TICKS);
            end else if (pause_rise)
               state_n = PAUSED;
         end
         DYING:
            if (expire) begin
               state_n  = lives_left == 4'd0 ? GAME_OVER_S : READY;
               sprite_n = lives_left != 4'd0;
               timer_n  = lives_left == 4'd0 ? timer_n : TICK_W'(READY_TICKS);
            end
         LEVEL_CLEAR:
            if (expire) begin
               state_n  = READY;
               level_n  = level == 4'd15 ? level : level + 4'd1;
               food_n   = '0;
               reload_n = 1'b1;
               sprite_n = 1'b1;
               timer_n  = TICK_W'(READY_TICKS);
            end
         PAUSED: state_n = pause_rise ? PLAY : PAUSED;
         default: state_n = ATTRACT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cur          <= ATTRACT;
         timer        <= '0;
         food_cnt     <= '0;
         lives_left   <= 4'(LIVES);
         level        <= 4'd1;
         move_en      <= 1'b0;
         sprite_reset <= 1'b0;
         score_clear  <= 1'b0;
         food_reload  <= 1'b0;
         game_over    <= 1'b0;
         start_prev   <= 1'b1;
      end else begin
         cur          <= state_n;
         timer        <= timer_n;
         food_cnt     <= food_n;
         lives_left   <= lives_n;
         level        <= level_n;
         move_en      <= state_n == PLAY;
         sprite_reset <= sprite_n;
         score_clear  <= score_n;
         food_reload  <= reload_n;
         game_over    <= state_n == GAME_OVER_S;
         start_prev   <= start_btn;
      end
   end
endmodule

// File: doc/game_flow_controller.md
Name: game_flow_controller

Overview:
- Top-level sequencer for the gameplay datapath: sprite position update, ghost control, collision and food/score logic.
- Owns the game state machine (attract, ready, play, dying, level clear, game over), the lives counter, the level counter and the pellet-eaten count.
- Drives the global move enable, sprite/position reset pulse, score clear and food-map reload pulses back into the game logic.
- All timing is expressed in frame ticks, so freeze durations are independent of the system clock rate.

Parameters:
- LIVES, 3: lives granted at game start; range 1..15.
- READY_TICKS, 120: frame ticks spent frozen in READY before play resumes.
- DEATH_TICKS, 90: frame ticks spent in DYING after a collision.
- CLEAR_TICKS, 120: frame ticks spent in LEVEL_CLEAR.
- FOOD_TOTAL, 12'd1000: pellets per level; reaching this count clears the level.
- TICK_W, 8: width of the freeze-timer counter; must hold max(READY_TICKS, DEATH_TICKS, CLEAR_TICKS).

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset; synchronous, active-high.
- frame_tick  in  1  one-clk pulse per video frame.
- start_btn  in  1  start request, already debounced, level-sensitive.
- pacman_is_dead  in  1  OR of ghost collision flags, level.
- food_eaten  in  1  one-clk pulse per pellet eaten.
- state  out  3  0 ATTRACT, 1 READY, 2 PLAY, 3 DYING, 4 LEVEL_CLEAR, 5 GAME_OVER, 6 PAUSED.
- move_en  out  1  high only in PLAY; gates all sprite position updates.
- sprite_reset  out  1  one-clk pulse: return all sprites to spawn positions.
- score_clear  out  1  one-clk pulse: zero the total score.
- food_reload  out  1  one-clk pulse: refill the food map.
- lives_left  out  4  remaining lives.
- level  out  4  current level, starting at 1.
- game_over  out  1  high while state==GAME_OVER.

Behaviour:
- Reset (synchronous): state=ATTRACT, move_en=0, all pulses=0, lives_left=LIVES, level=1, food_cnt=0, timer=0, game_over=0. Reset asserted mid-state aborts immediately; no pulses fire on the reset cycle.
- start_btn is edge-detected internally using a registered previous value, which is reset to 1. A button held through reset does not start a game.
- All outputs are registered, giving 1 clk latency from the causing input.
- ATTRACT:
  - On a start_btn rising edge go to READY.
  - In the same cycle pulse sprite_reset, score_clear and food_reload.
  - Load lives_left=LIVES, level=1, food_cnt=0, timer=READY_TICKS.
- READY:
  - Each frame_tick decrements timer.
  - On the tick where timer==1, go to PLAY.
  - pacman_is_dead and food_eaten are ignored.
- PLAY:
  - move_en=1.
  - food_eaten increments the 12-bit food_cnt.
  - pacman_is_dead=1 (sampled each clk): go to DYING, lives_left-=1, timer=DEATH_TICKS.
  - Otherwise, when food_cnt reaches FOOD_TOTAL (including via this cycle's increment): go to LEVEL_CLEAR, timer=CLEAR_TICKS.
  - If death and the final pellet coincide, death has priority; food_cnt still increments.
- DYING:
  - Timer counts down on frame_tick.
  - At expiry, if lives_left==0: go to GAME_OVER.
  - Otherwise: go to READY, pulse sprite_reset, timer=READY_TICKS. The food map and score are kept.
- LEVEL_CLEAR:
  - At expiry: level+=1 (saturates at 15), food_cnt=0.
  - Pulse food_reload and sprite_reset, then go to READY with timer=READY_TICKS.
- GAME_OVER:
  - game_over=1; lives_left and level are held for display.
  - A start_btn rising edge starts a new game with the same actions as from ATTRACT.
- A frame_tick is counted at most once per clk. The timer never underflows; the transition happens on the tick that takes it from 1 to 0.
- Any state encoding outside 0..6 returns to ATTRACT on the next clk.

Optional Feature:
- Macro GAME_FLOW_PAUSE_EN.
- When defined:
  - Adds input pause_btn (1 bit, debounced, internally edge-detected).
  - A rising edge in PLAY goes to PAUSED (move_en=0, timers frozen, food_eaten and pacman_is_dead ignored).
  - A rising edge in PAUSED returns to PLAY.
  - In all other states pause_btn is ignored.
- When undefined: no pause_btn port, and state 6 is unreachable.

Test Plan (LIVES=2, READY_TICKS=2, DEATH_TICKS=3, CLEAR_TICKS=2, FOOD_TOTAL=4):
- Reset, then start_btn rise -> state=1, one-clk sprite_reset, score_clear and food_reload pulses, lives_left=2, level=1; after 2 frame_ticks state=2 and move_en=1.
- In PLAY, 4 food_eaten pulses -> state=4; after 2 frame_ticks level=2, one food_reload pulse, state=1.
- In PLAY, assert pacman_is_dead -> state=3, lives_left=1, move_en=0 next clk; after 3 ticks state=1 with a sprite_reset pulse; a second death -> lives_left=0 -> state=5, game_over=1.
- 4th food_eaten coincides with pacman_is_dead -> state=3, not 4; lives_left decremented.
- Hold start_btn high through reset release -> stays ATTRACT; a later low-to-high edge starts the game. Assert rst during DYING -> ATTRACT next clk, lives_left=2, no pulses.
- With GAME_FLOW_PAUSE_EN: pause_btn edge in PLAY -> state=6 and move_en=0; frame_ticks and food_eaten have no effect; a second edge -> state=2.
